// File: rtl/banked_byte_ram.sv
`default_nettype none
// ============================================================================
// Module   : banked_byte_ram
// Purpose  : Single-clock RAM with byte-masked writes, a registered read port
//            and a post-reset clear sequencer. Collision behaviour is
//            write-first if BANKED_RAM_FORWARD_EN is defined, otherwise
//            read-first. DEBUG_DISPLAY enables write tracing.
// Revision : 1.0 - initial release
// ============================================================================
module banked_byte_ram #(
   parameter int    WIDTH      = 32,
   parameter int    ADDR_WIDTH = 8,
   parameter string TAG        = "RAM"
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  re,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] readAddr,
   input  logic [ADDR_WIDTH-1:0] writeAddr,
   input  logic [WIDTH-1:0]      dataIn,
   input  logic [WIDTH/8-1:0]    byteEn,
   output logic [WIDTH-1:0]      dataOut,
   output logic                  readValid,
   output logic                  busy
);

   localparam int SIZE   = 1 << ADDR_WIDTH;
   localparam int NBYTES = WIDTH / 8;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t                  state;
   state_t                  next_state;
   logic [ADDR_WIDTH-1:0]   clr_cnt;
   logic                    accept_rd;
   logic                    accept_wr;
   logic [WIDTH-1:0]        rd_word;
   logic [WIDTH-1:0]        mem [SIZE];

   if (WIDTH == 0 || (WIDTH % 8) != 0) begin : g_bad_width
      $error("[%s] WIDTH must be a nonzero multiple of 8", TAG);
   end

   always_ff @(posedge clk) begin
      if (!res) begin
         state <= CLEAR;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      accept_rd  = 1'b0;
      accept_wr  = 1'b0;
      case (state)
         CLEAR: begin
            if (&clr_cnt) begin
               next_state = READY;
            end
         end
         READY: begin
            accept_rd = re;
            accept_wr = we;
         end
         default: next_state = CLEAR;
      endcase
   end

   // Counter wraps back to 0 on the final clear write, leaving it ready for a restart.
   always_ff @(posedge clk) begin
      if (!res) begin
         clr_cnt <= '0;
         busy    <= 1'b1;
      end else begin
         if (state == CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
         end
         busy <= (next_state == CLEAR);
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
         end else if (accept_wr) begin
            for (int i = 0; i < NBYTES; i++) begin
               if (byteEn[i]) begin
                  mem[writeAddr][8*i +: 8] <= dataIn[8*i +: 8];
               end
            end
         end
      end
   end

`ifdef BANKED_RAM_FORWARD_EN
   // Write-first: enabled bytes of a same-address write bypass the array.
   for (genvar i = 0; i < NBYTES; i++) begin : g_fwd_byte
      assign rd_word[8*i +: 8] = (accept_wr && byteEn[i] && (readAddr == writeAddr))
                                 ? dataIn[8*i +: 8]
                                 : mem[readAddr][8*i +: 8];
   end
`else
   assign rd_word = mem[readAddr];
`endif

   always_ff @(posedge clk) begin
      if (!res) begin
         dataOut   <= '0;
         readValid <= 1'b0;
      end else begin
         readValid <= accept_rd;
         if (accept_rd) begin
            dataOut <= rd_word;
         end
      end
   end

`ifdef DEBUG_DISPLAY
   always_ff @(posedge clk) begin
      if (res && accept_wr) begin
         $display("[%s] write data=%h addr=%h mask=%b", TAG, dataIn, writeAddr, byteEn);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_banked_byte_ram.sv
`default_nettype none
// Testbench for banked_byte_ram: random and directed traffic against an
// array-based reference model, checked by a scoreboard monitor.
module tb_banked_byte_ram;

   localparam int SZ = 256;

   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic        re = 1'b0;
   logic        we = 1'b0;
   logic [7:0]  readAddr = '0;
   logic [7:0]  writeAddr = '0;
   logic [31:0] dataIn = '0;
   logic [3:0]  byteEn = '0;
   logic [31:0] dataOut;
   logic        readValid;
   logic        busy;

   always #5 clk = ~clk;

   banked_byte_ram #(
      .WIDTH      (32),
      .ADDR_WIDTH (8),
      .TAG        ("RAM")
   ) dut (
      .clk       (clk),
      .res       (res),
      .re        (re),
      .we        (we),
      .readAddr  (readAddr),
      .writeAddr (writeAddr),
      .dataIn    (dataIn),
      .byteEn    (byteEn),
      .dataOut   (dataOut),
      .readValid (readValid),
      .busy      (busy)
   );

   typedef struct {
      bit          valid;
      bit          busy;
      logic [31:0] data;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] model [SZ];
   int          clear_left = SZ;
   logic [31:0] out_hold = '0;
   int          total = 0;
   int          bad = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      end
      return r;
   endfunction

   // One clock: drive at the falling edge, then update the model at the rising edge.
   task automatic step(input bit rn, input bit r, input bit w, input logic [7:0] ra,
                       input logic [7:0] wa, input logic [31:0] d, input logic [3:0] be);
      exp_t        e;
      logic [31:0] v;
      @(negedge clk);
      res = rn; re = r; we = w; readAddr = ra; writeAddr = wa; dataIn = d; byteEn = be;
      @(posedge clk);
      e.valid = 1'b0;
      if (!rn) begin
         clear_left = SZ;
         out_hold   = '0;
      end else if (clear_left > 0) begin
         clear_left--;
         if (clear_left == 0) begin
            foreach (model[i]) model[i] = '0;
         end
      end else begin
         if (r) begin
            v = model[ra];
`ifdef BANKED_RAM_FORWARD_EN
            if (w && ra == wa) v = merge(model[ra], d, be);
`endif
            out_hold = v;
            e.valid  = 1'b1;
         end
         if (w) model[wa] = merge(model[wa], d, be);
      end
      e.busy = (clear_left != 0);
      e.data = out_hold;
      sbq.push_back(e);
   endtask

   task automatic rnd_step(input bit rn, input int amax);
      step(rn, 1'($urandom), 1'($urandom), 8'($urandom_range(0, amax)),
           8'($urandom_range(0, amax)), $urandom, 4'($urandom));
   endtask

   // Monitor: one scoreboard entry per clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("busy", 32'(busy), 32'(e.busy));
            chk("readValid", 32'(readValid), 32'(e.valid));
            chk("dataOut", dataOut, e.data);
         end
      end
   end

   initial begin
      step(0, 1, 1, 8'h00, 8'h00, 32'h0, 4'h0);
      step(0, 1, 1, 8'h05, 8'h05, 32'hFFFF_FFFF, 4'hF);
      // Clear runs 100 cycles with ignored traffic, then a one-cycle reset restarts it.
      for (int i = 0; i < 100; i++) rnd_step(1, 255);
      step(0, 1, 1, 8'h10, 8'h10, 32'h1234_5678, 4'hF);
      for (int i = 0; i < SZ; i++) rnd_step(1, 255);

      step(1, 1, 0, 8'h00, 8'h00, 32'h0, 4'h0);
      step(1, 1, 0, 8'h7F, 8'h00, 32'h0, 4'h0);
      step(1, 1, 0, 8'hFF, 8'h00, 32'h0, 4'h0);

      step(1, 0, 1, 8'h00, 8'h10, 32'hDEAD_BEEF, 4'b1111);
      step(1, 0, 1, 8'h00, 8'h10, 32'h1122_3344, 4'b0101);
      step(1, 1, 0, 8'h10, 8'h00, 32'h0, 4'h0);

      step(1, 0, 1, 8'h00, 8'h20, 32'hAAAA_AAAA, 4'hF);
      step(1, 1, 1, 8'h20, 8'h20, 32'h5555_5555, 4'b0011);
      step(1, 1, 0, 8'h20, 8'h00, 32'h0, 4'h0);

      step(1, 0, 1, 8'h00, 8'h31, 32'hCAFE_F00D, 4'hF);
      step(1, 1, 1, 8'h31, 8'h30, 32'h0BAD_C0DE, 4'hF);
      step(1, 1, 0, 8'h30, 8'h00, 32'h0, 4'h0);

      step(1, 0, 0, 8'h00, 8'h00, 32'h0, 4'h0);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 8'h10 + 8'(i * 16), 8'h00, 32'h0, 4'h0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 8'h00, 32'h0, 4'h0);

      // Narrow address range makes collisions frequent.
      for (int i = 0; i < 400; i++) rnd_step(1, 7);
      for (int i = 0; i < 2; i++) step(1, 0, 0, 8'h00, 8'h00, 32'h0, 4'h0);

      @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
